cla_nibble_seq_ctrl: RTL
========================

// Module: cla_nibble_seq_ctrl
// PURPOSE
//  Multi-cycle WIDTH-bit add/subtract unit: sequences one 4-bit carry-look-ahead slice over the operand
//  nibbles LSB-first, one nibble per clock, carrying between nibbles in a register. Sits between a
//  valid/ready producer and consumer; trades latency for area versus a full-width CLA tree.
// PARAMETERS
//  WIDTH    16   operand/result width in bits; must be a multiple of 4 and >= 8
//  NIBBLES  WIDTH/4   derived, not overridden; number of slice passes per operation
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operation request valid
//  in_ready   out  1      unit can accept a request (IDLE only)
//  op_a       in   WIDTH  operand A
//  op_b       in   WIDTH  operand B
//  op_cin     in   1      carry-in for add; ignored when op_sub=1
//  op_sub     in   1      1: A - B (B inverted, carry-in forced 1); 0: A + B + op_cin
//  out_valid  out  1      result valid (DONE state)
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  sum/difference
//  cout       out  1      carry out of bit WIDTH-1 (for sub: 1 = no borrow)
//  ovf        out  1      two's-complement overflow
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  Reset: state=IDLE, nibble index=0, carry reg=0, all operand/result regs 0; in_ready=1, out_valid=0,
//   result=0, cout=0, ovf=0, busy=0. Reset asserted mid-operation aborts it; no result is produced.
//  FSM IDLE -> RUN -> DONE -> IDLE:
//   IDLE: in_ready=1. in_valid&in_ready at edge: latch op_a, b_eff = op_sub ? ~op_b : op_b,
//     carry = op_sub ? 1 : op_cin, idx=0, -> RUN. op_* ignored when not handshaking.
//   RUN: slice adds a[4*idx+:4], b_eff[4*idx+:4], carry; at each edge sum nibble written to
//     result[4*idx+:4], carry <= slice cout, idx++. When idx==NIBBLES-1 at edge: -> DONE, cout and
//     ovf latched from this final pass.
//   DONE: out_valid=1, result/cout/ovf stable until out_valid&out_ready edge, then -> IDLE.
//  Latency: accepted at edge k -> out_valid high after edge k+NIBBLES (4 cycles at WIDTH=16).
//  Throughput: one op per NIBBLES+2 cycles min; in_ready=0 in RUN and DONE (no overlap, no bypass).
//  in_valid in RUN/DONE is not accepted and must be held by the producer (standard valid/ready).
//  Arithmetic: modulo 2^WIDTH. ovf = (a[W-1] == b_eff[W-1]) & (result[W-1] != a[W-1]).
//  out_ready high while out_valid=0 has no effect. result holds last value after return to IDLE
//   until overwritten nibble-by-nibble by the next op (consumer must only sample with out_valid).
//  Slice: g=a&b, p=a^b, full look-ahead c(i+1)=g(i)|p(i)&c(i) expanded from cin, sum=p^c. Combinational.
// STRUCTURE
//  Shared package (cla_pkg): state enum {IDLE,RUN,DONE} (2-bit), SLICE_W=4 constant.
//  Sub-module cla4_slice (a[3:0], b[3:0], cin -> sum[3:0], cout): one instance, combinational.
//  Controller: FSM, idx counter ($clog2(NIBBLES) bits), carry reg, A/B_eff shift-or-index regs, result reg.
// TESTING (WIDTH=16)
//  Add: A=0x1234,B=0x4321,cin=0,sub=0 -> result=0x5555,cout=0,ovf=0; out_valid 4 cycles after accept.
//  Carry chain: A=0xFFFF,B=0x0001,cin=0 -> result=0x0000,cout=1,ovf=0; also A=0x000F,B=0,cin=1 -> 0x0010.
//  Subtract/overflow: A=0x8000,B=0x0001,sub=1 -> result=0x7FFF,cout=1,ovf=1; A=0x0003,B=0x0005,sub=1
//   -> 0xFFFE,cout=0,ovf=0. Also A=0x7FFF,B=1,add -> 0x8000,ovf=1.
//  Backpressure: hold out_ready=0 10 cycles in DONE -> outputs stable, in_ready=0, second in_valid
//   not accepted until cycle after out_ready handshake.
//  Reset mid-RUN (after 2 nibbles): -> in_ready=1,out_valid=0,result=0 next cycle; next op correct.
//  Random: 1000 back-to-back ops vs. reference model (A+B+cin / A-B), check result/cout/ovf, latency.

Source files
------------

// File: rtl/cla_nibble_seq_ctrl_pkg.sv
// Shared types and constants for the nibble-serial carry-look-ahead add/subtract unit.
package cla_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_nibble_seq_ctrl_slice.sv
// Combinational 4-bit carry-look-ahead adder slice with all carries expanded from cin.
module cla4_slice
  import cla_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum-of-products of g, p and cin; no ripple path.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[SLICE_W-1:0];
  assign cout = c[SLICE_W];

endmodule

// File: rtl/cla_nibble_seq_ctrl.sv
// Multi-cycle add/subtract: one CLA slice walks the operand nibbles LSB-first, one per clock,
// with the inter-nibble carry held in a register; valid/ready on both sides.
module cla_nibble_seq_ctrl
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / SLICE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t             state_q;
  state_t             state_d;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   result_q;
  logic               cout_q;
  logic               ovf_q;

  logic [IDX_W+1:0]   base;
  logic [SLICE_W-1:0] a_nib;
  logic [SLICE_W-1:0] b_nib;
  logic [SLICE_W-1:0] sum_nib;
  logic               slice_cout;
  logic               accept;
  logic               last_pass;
  logic               slice_ovf;

  assign base      = {idx_q, 2'b00};
  assign a_nib     = a_q[base +: SLICE_W];
  assign b_nib     = b_q[base +: SLICE_W];
  assign accept    = (state_q == IDLE) && in_valid;
  assign last_pass = (state_q == RUN) && (idx_q == LAST_IDX);

  // On the final pass the slice's bit 3 inputs/output are the operand and result sign bits.
  assign slice_ovf = (a_nib[SLICE_W-1] == b_nib[SLICE_W-1]) &&
                     (sum_nib[SLICE_W-1] != a_nib[SLICE_W-1]);

  cla4_slice u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .sum  (sum_nib),
    .cout (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      idx_q   <= '0;
      a_q     <= op_a;
      b_q     <= op_sub ? ~op_b : op_b;
      carry_q <= op_sub ? 1'b1 : op_cin;
    end else if (state_q == RUN) begin
      result_q[base +: SLICE_W] <= sum_nib;
      carry_q                   <= slice_cout;
      idx_q                     <= idx_q + 1'b1;
      if (last_pass) begin
        cout_q <= slice_cout;
        ovf_q  <= slice_ovf;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
